// File: rtl/reg_file_if.sv
// Register-file access bus: one write port, two operand read ports, one debug
// read port and the write-activity status outputs.
interface reg_file_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             we;
    logic [4:0]       waddr;
    logic [WIDTH-1:0] wdata;
    logic [4:0]       raddr1;
    logic [4:0]       raddr2;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic [4:0]       dbg_addr;
    logic [WIDTH-1:0] dbg_data;
    logic [15:0]      wr_count;
    logic             wr_zero;

    // Side that issues writes and read indices (core / testbench).
    modport master (
        output we, waddr, wdata, raddr1, raddr2, dbg_addr,
        input  rdata1, rdata2, dbg_data, wr_count, wr_zero
    );

    // Side that owns the storage (reg_file).
    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
        output rdata1, rdata2, dbg_data, wr_count, wr_zero
    );
endinterface

// File: rtl/reg_file.sv
// 32 x WIDTH register file with r0 hardwired to zero, write-first bypass on the
// two operand read ports, a non-bypassed debug read port, a saturating count of
// committed writes and a sticky flag for attempted writes to r0.
module reg_file #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    reg_file_if.slave bus
);

    logic [WIDTH-1:0] regs_q [32];
    logic [15:0]      wr_count_q;
    logic             wr_zero_q;
    logic             commit;
    logic             zero_hit;

    // Decode whether this edge commits a write; reset and r0 both block it.
    // Gating on we first keeps an undriven waddr from mattering while idle.
    always_comb begin
        commit   = 1'b0;
        zero_hit = 1'b0;
        if (bus.we && !rst) begin
            commit   = (bus.waddr != 5'd0);
            zero_hit = (bus.waddr == 5'd0);
        end
    end

    // Storage: clear everything on reset, otherwise commit the decoded write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

    // Write statistics: saturating commit counter and sticky r0-write flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_q <= 16'd0;
            wr_zero_q  <= 1'b0;
        end else begin
            if (commit && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (zero_hit) begin
                wr_zero_q <= 1'b1;
            end
        end
    end

    // Combinational reads; operand ports see the in-flight write (write-first),
    // the debug port always shows committed contents.
    always_comb begin
        bus.rdata1   = '0;
        bus.rdata2   = '0;
        bus.dbg_data = '0;
        if (bus.raddr1 != 5'd0) begin
            bus.rdata1 = regs_q[bus.raddr1];
        end
        if (bus.raddr2 != 5'd0) begin
            bus.rdata2 = regs_q[bus.raddr2];
        end
        if (bus.dbg_addr != 5'd0) begin
            bus.dbg_data = regs_q[bus.dbg_addr];
        end
        if (commit && (bus.raddr1 == bus.waddr)) begin
            bus.rdata1 = bus.wdata;
        end
        if (commit && (bus.raddr2 == bus.waddr)) begin
            bus.rdata2 = bus.wdata;
        end
    end

    // Status outputs.
    always_comb begin
        bus.wr_count = wr_count_q;
        bus.wr_zero  = wr_zero_q;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: WIDTH, default 32, data width of every register and data port.
REQ-002 Clocking: one clock, clk; reset rst is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: we  input  1  write enable.
REQ-006 Port: waddr  input  5  write register index; the 5-bit destination-select mux (rt/rd select) drives it.
REQ-007 Port: wdata  input  WIDTH  write data.
REQ-008 Port: raddr1  input  5  read port 1 index (rs).
REQ-009 Port: raddr2  input  5  read port 2 index (rt).
REQ-010 Port: rdata1  output  WIDTH  read port 1 data.
REQ-011 Port: rdata2  output  WIDTH  read port 2 data.
REQ-012 Port: dbg_addr  input  5  debug read index.
REQ-013 Port: dbg_data  output  WIDTH  debug read data.
REQ-014 Port: wr_count  output  16  count of committed writes, saturating.
REQ-015 Port: wr_zero  output  1  sticky flag: a write to register 0 was attempted.

Function
REQ-016 Storage SHALL be 32 registers of WIDTH bits, indices 0..31.
REQ-017 A write commits on a rising clk edge when we=1, rst=0 and waddr!=0: reg[waddr] <= wdata.
REQ-018 Register 0 SHALL always read 0; a write with waddr=0 SHALL leave all storage unchanged.
REQ-019 Reads on rdata1, rdata2 and dbg_data SHALL be combinational from the addressed register, with zero-cycle latency.
REQ-020 Bypass: when we=1, waddr!=0 and raddrN==waddr, rdataN SHALL equal wdata in the same cycle (write-first); dbg_data SHALL NOT bypass.
REQ-021 Both read ports MAY address the same register; each SHALL return identical data.
REQ-022 wr_count SHALL increment by 1 on each committed write (REQ-017) and SHALL saturate at 16'hFFFF with no wrap.
REQ-023 wr_zero SHALL be set at the edge where we=1 and waddr=0, and SHALL stay set until rst.
REQ-024 When we=0, waddr and wdata SHALL be ignored, including for bypass.
REQ-025 Values of X/Z on waddr while we=0 SHALL NOT corrupt storage.

Reset
REQ-026 On a rising edge with rst=1, all 32 registers SHALL clear to 0.
REQ-027 On a rising edge with rst=1, wr_count SHALL clear to 0 and wr_zero SHALL clear to 0.
REQ-028 rst SHALL take priority over a simultaneous write, so no write commits in that cycle.
REQ-029 Bypass SHALL be suppressed while rst=1, so rdataN shows the pre-edge register value, and 0 after the edge.
REQ-030 Reset asserted mid-run SHALL take effect at the next edge only; before that edge, reads SHALL return current contents.

Verification
REQ-031 Reset then read all indices on all three read ports -> every read is 0; wr_count=0; wr_zero=0.
REQ-032 Write 32'hDEADBEEF to reg 5; next cycle set raddr1=5 and raddr2=5 -> both read 32'hDEADBEEF; wr_count=1.
REQ-033 Write 32'h12345678 to reg 0 -> rdata1 at raddr1=0 reads 0; wr_zero=1; wr_count unchanged.
REQ-034 Hold reg 7=32'h1 and drive we=1, waddr=7, wdata=32'h2, raddr1=7 in the same cycle -> rdata1=32'h2 before the edge, while dbg_data at dbg_addr=7 reads 32'h1; after the edge both read 32'h2.
REQ-035 Assert rst together with a write of 32'hAA to reg 3 -> reg 3 reads 0 after the edge; wr_count=0.
REQ-036 Perform 65537 writes to reg 1 -> wr_count=16'hFFFF and reg 1 holds the last data written.
